// File: rtl/xmem_stream_ctrl.sv
// Single-port word memory with direct instruction access and a burst-read streaming engine.
// Build macro XMEM_PARITY_EN adds an even-parity bit per stored word and drives par_err.
module xmem_stream_ctrl #(
    parameter int DW    = 32,
    parameter int DEPTH = 2048,
    parameter int AW    = 11,
    parameter int LW    = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cen,
    input  logic          wen,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] d,
    output logic [DW-1:0] q,
    input  logic          burst_start,
    input  logic [AW-1:0] burst_base,
    input  logic [LW-1:0] burst_len,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          access_drop,
    output logic          par_err
);

`ifdef XMEM_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif
    localparam logic [AW:0]   DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_L  = AW'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

    logic [MW-1:0] mem_q [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] remain_q;
    logic [DW-1:0] fifo_q [2];
    logic [1:0]    err_q;
    logic          head_q;
    logic [1:0]    cnt_q, cnt_d;
    logic [DW-1:0] q_q;
    logic          done_q, busy_q, drop_q, par_q;

    logic          idle, start, addr_ok, dir_wr, dir_rd, issue, pop, rd_err, head_err_d;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] wr_word, rd_word;

    assign idle    = (state_q == IDLE);
    assign start   = idle && burst_start;
    assign addr_ok = ({1'b0, addr} < DEPTH_L);
    assign dir_wr  = idle && !burst_start && !cen && !wen && addr_ok;
    assign dir_rd  = idle && !burst_start && !cen &&  wen && addr_ok;

    // A read is only issued when the 2-entry output buffer has a free slot,
    // so backpressure can never overwrite an unaccepted word.
    assign issue = (state_q == STREAM) && (cnt_q != 2'd2);
    assign pop   = (cnt_q != 2'd0) && out_ready;
    assign cnt_d = cnt_q + {1'b0, issue} - {1'b0, pop};

    assign mem_addr = (state_q == STREAM) ? rd_ptr_q : addr;
    assign rd_word  = mem_q[mem_addr];

`ifdef XMEM_PARITY_EN
    assign wr_word = {^d, d};
    assign rd_err  = ^rd_word;
`else
    assign wr_word = d;
    assign rd_err  = 1'b0;
`endif

    // Error flag of the word that becomes the buffer head at this edge, if any.
    always_comb begin
        head_err_d = 1'b0;
        if (issue && ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && pop)))
            head_err_d = rd_err;
        else if (pop && (cnt_q == 2'd2))
            head_err_d = err_q[~head_q];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (burst_start) state_d = (burst_len == '0) ? DONE : STREAM;
            STREAM:  if (issue && (remain_q == LW'(1))) state_d = DRAIN;
            DRAIN:   if (cnt_d == 2'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (dir_wr) mem_q[addr] <= wr_word;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rd_ptr_q  <= '0;
            remain_q  <= '0;
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            err_q     <= '0;
            head_q    <= 1'b0;
            cnt_q     <= '0;
            q_q       <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= 1'b0;
            par_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == DONE);
            busy_q  <= (state_d != IDLE);
            drop_q  <= !cen && (!idle || burst_start);
            par_q   <= (dir_rd && rd_err) || head_err_d;
            cnt_q   <= cnt_d;
            if (start) begin
                rd_ptr_q <= burst_base;
                remain_q <= burst_len;
            end
            if (issue) begin
                rd_ptr_q <= (rd_ptr_q == LAST_L) ? '0 : rd_ptr_q + AW'(1);
                remain_q <= remain_q - LW'(1);
                fifo_q[head_q ^ cnt_q[0]] <= rd_word[DW-1:0];
                err_q[head_q ^ cnt_q[0]]  <= rd_err;
            end
            if (pop) head_q <= ~head_q;
            if (dir_rd) q_q <= rd_word[DW-1:0];
        end
    end

    assign q           = q_q;
    assign out_data    = fifo_q[head_q];
    assign out_valid   = (cnt_q != 2'd0);
    assign busy        = busy_q;
    assign done        = done_q;
    assign access_drop = drop_q;
    assign par_err     = par_q;

endmodule

// File: tb/tb_xmem_stream_ctrl.sv
// Directed + randomized bench for xmem_stream_ctrl against a word-array / queue reference model.
module tb_xmem_stream_ctrl;
    localparam int DW = 32, DEPTH = 2048, AW = 11, LW = 12;

    logic          clk = 1'b0, reset = 1'b1;
    logic          cen = 1'b1, wen = 1'b1;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] d = '0;
    logic [DW-1:0] q;
    logic          burst_start = 1'b0;
    logic [AW-1:0] burst_base = '0;
    logic [LW-1:0] burst_len = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy, done, access_drop, par_err;

    logic [DW-1:0] ref_mem [DEPTH];
    int total = 0, bad = 0;

    xmem_stream_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
        .clk(clk), .reset(reset), .cen(cen), .wen(wen), .addr(addr), .d(d), .q(q),
        .burst_start(burst_start), .burst_base(burst_base), .burst_len(burst_len),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .access_drop(access_drop), .par_err(par_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dwrite(input int a, input logic [DW-1:0] v);
        cen = 1'b0; wen = 1'b0; addr = AW'(a); d = v;
        tick;
        cen = 1'b1; wen = 1'b1;
        ref_mem[a] = v;
    endtask

    task automatic dread_chk(input int a, input string tag);
        cen = 1'b0; wen = 1'b1; addr = AW'(a);
        tick;
        cen = 1'b1;
        $display("direct read addr=%0d q=%08h", a, q);
        chk(tag, q, ref_mem[a]);
        chk({tag, "_par"}, par_err, 1'b0);
    endtask

    // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic run_burst(input int base, input int len, input int mode, input bit collide);
        logic [DW-1:0] expq[$];
        logic [DW-1:0] pd = '0;
        logic pv = 1'b0, pr = 1'b0;
        int got = 0, c = 0, first_c = -1, done_c = -1;
        for (int i = 0; i < len; i++) expq.push_back(ref_mem[(base + i) % DEPTH]);
        out_ready   = (mode == 0);
        burst_base  = AW'(base);
        burst_len   = LW'(len);
        burst_start = 1'b1;
        if (collide) begin
            cen = 1'b0; wen = 1'b0; addr = AW'(100); d = 32'hCAFE_F00D;
        end
        tick;
        burst_start = 1'b0;
        cen = 1'b1; wen = 1'b1;
        chk("drop_at_start", access_drop, collide);
        chk("busy_at_start", busy, 1'b1);
        while (done_c < 0 && c < 40 + 4 * len) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
            if (pv && !pr) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, pd);
            end
            if (out_valid && first_c < 0) first_c = c;
            if (out_valid && out_ready) begin
                if (expq.size() > 0) chk($sformatf("word%0d", got), out_data, expq.pop_front());
                got++;
            end
            if (done) done_c = c;
            pv = out_valid; pr = out_ready; pd = out_data;
            tick;
            c++;
        end
        $display("burst base=%0d len=%0d mode=%0d words=%0d first=%0d done_at=%0d",
                 base, len, mode, got, first_c, done_c);
        chk("burst_timeout", done_c >= 0, 1'b1);
        chk("word_count", got, len);
        chk("busy_after", busy, 1'b0);
        chk("done_pulse_end", done, 1'b0);
        chk("valid_after", out_valid, 1'b0);
        if (mode == 0) begin
            chk("first_latency", first_c, (len > 0) ? 1 : -1);
            chk("done_cycle", done_c, (len > 0) ? len + 1 : 0);
        end
    endtask

    initial begin
        tick;
        tick;
        chk("rst_q", q, '0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_drop", access_drop, 1'b0);
        chk("rst_par", par_err, 1'b0);
        reset = 1'b0;
        tick;

        for (int i = 0; i < DEPTH; i++) dwrite(i, $urandom);

        // direct write/read of a known word, q latency and hold
        dwrite(5, 32'hDEAD_BEEF);
        chk("q_before_read", q, '0);
        dread_chk(5, "read5");
        tick;
        tick;
        chk("q_hold", q, 32'hDEAD_BEEF);

        for (int i = 0; i < 16; i++) begin
            int a = $urandom_range(0, DEPTH - 1);
            if ($urandom_range(0, 1) == 1) dwrite(a, $urandom);
            else dread_chk(a, "rand_read");
        end

        for (int i = 0; i < 8; i++) dwrite(i, DW'(i));
        run_burst(0, 8, 0, 1'b0);
        run_burst(0, 8, 1, 1'b0);

        dwrite(2046, 32'h1111_2046);
        dwrite(2047, 32'h2222_2047);
        dwrite(0, 32'h3333_0000);
        dwrite(1, 32'h4444_0001);
        run_burst(2046, 4, 0, 1'b0);
        run_burst(5, 0, 0, 1'b0);

        run_burst(10, 3, 0, 1'b1);
        dread_chk(100, "collide_no_write");

        // reset in the middle of a stalled burst
        burst_base = '0; burst_len = LW'(8); burst_start = 1'b1; out_ready = 1'b0;
        tick;
        burst_start = 1'b0;
        tick;
        tick;
        tick;
        chk("mid_valid", out_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        tick;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("midrst_no_done", done, 1'b0);
            tick;
        end
        run_burst(0, 8, 0, 1'b0);

        for (int i = 0; i < 4; i++)
            run_burst($urandom_range(0, DEPTH - 1), $urandom_range(1, 20), 2, 1'b0);

`ifdef XMEM_PARITY_EN
        dwrite(3, 32'h0F0F_0001);
        dut.mem_q[3][0] = ~dut.mem_q[3][0];
        cen = 1'b0; wen = 1'b1; addr = AW'(3);
        tick;
        cen = 1'b1;
        chk("par_err_set", par_err, 1'b1);
        tick;
        chk("par_err_clear", par_err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/xmem_stream_ctrl.md
Name: xmem_stream_ctrl

Overview:
Parametrised activation/weight memory block: an internal single-port synchronous SRAM array plus controller. It keeps direct instruction-driven access (active-low chip enable and write enable, address, data) and adds a burst-read streaming engine. The engine walks a contiguous address range and delivers words to the L0/IFIFO side over a valid/ready handshake with backpressure. It sits between the testbench/instruction path and the PE-array input buffers.

Parameters:
DW, 32, word width in bits (bw*row)
DEPTH, 2048, words in array
AW, 11, address width; DEPTH <= 2**AW
LW, 12, burst length field width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cen  in  1  direct-access chip enable, active low
wen  in  1  direct-access write enable, active low (write when cen=0,wen=0)
addr  in  AW  direct-access address
d  in  DW  direct-access write data
q  out  DW  direct-access read data
burst_start  in  1  start-streaming pulse
burst_base  in  AW  first address of burst
burst_len  in  LW  number of words to stream
out_data  out  DW  streamed word
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts out_data
busy  out  1  engine not IDLE
done  out  1  one-cycle pulse after last word accepted
access_drop  out  1  one-cycle pulse: direct access ignored
par_err  out  1  parity error flag (optional feature)

Behaviour:
- Reset (async, active-high): q=0, out_valid=0, out_data=0, busy=0, done=0, access_drop=0, par_err=0; pointers/counters cleared; state IDLE; array contents not cleared. Reset mid-burst aborts it; no done pulse.
- Array: synchronous, one port, one access per cycle; read data registered, 1-cycle latency.
- Direct access only in IDLE: write at posedge when cen=0,wen=0; read when cen=0,wen=1 -> q updates next cycle; q holds otherwise. Out-of-range address (>= DEPTH) ignored, q holds.
- States: IDLE -> STREAM on burst_start (burst_len>0); IDLE -> DONE on burst_start with burst_len=0 (no data). STREAM -> DRAIN when last read issued; DRAIN -> DONE when output buffer empties; DONE -> IDLE after one cycle, done=1 in DONE. busy=1 in STREAM/DRAIN/DONE.
- burst_start while busy ignored. burst_base/burst_len sampled only at accepted start.
- Priority: burst_start and cen=0 in the same IDLE cycle -> burst wins, direct access dropped, access_drop=1. Any cen=0 while busy -> dropped, access_drop=1.
- Streaming: read pointer starts at burst_base, increments per issued read, wraps DEPTH-1 -> 0. Output side is a 2-entry buffer; read issued only when (occupancy + reads in flight) < 2, so no word lost under backpressure.
- Handshake: word transfers when out_valid && out_ready. Once asserted, out_valid and out_data are held stable until accepted. With out_ready held high, the first word is valid 2 cycles after the start cycle and one word follows per cycle.
- Word order is strictly ascending address (mod DEPTH). Exactly burst_len words are delivered.

Optional Feature:
XMEM_PARITY_EN: defined -> array is DW+1 wide; even parity is computed on every write and checked on every read (direct and stream). On mismatch, par_err=1 for one cycle, aligned with the q update or the out_valid word first presented. Undefined -> array is DW wide and par_err tied 0.

Test Plan:
- Direct write addr 5 = 0xDEADBEEF, then read addr 5 -> q=0xDEADBEEF exactly one cycle after the read cycle; q holds on idle cycles.
- Preload addrs 0..7 with value=addr; burst_base=0, burst_len=8, out_ready=1 -> out_data 0..7 on 8 consecutive cycles, first 2 cycles after start, then a done pulse; busy low afterwards.
- Same burst with out_ready toggling 1,0,0,1,... -> same 8 words in order, none duplicated or lost; out_data stable while out_valid && !out_ready.
- burst_base=2046, burst_len=4 -> addresses 2046, 2047, 0, 1 delivered; burst_len=0 -> done pulse, no out_valid.
- burst_start with cen=0 in the same cycle -> access_drop=1, no write occurs; reset asserted mid-burst -> out_valid=0, busy=0 immediately, no done; next burst runs correctly.
- With XMEM_PARITY_EN defined, force a flipped bit in the stored word at addr 3 and read it -> par_err=1 for exactly one cycle.
